// File: rtl/parity_gen.sv
// Parity generator/checker: combinational parity, a registered {data,parity} word and a received-word checker.
// Latency: parity 0 cycles; out_*/par_err/err_cnt 1 cycle. No backpressure: every valid input is accepted.
module parity_gen #(
    parameter int WIDTH   = 3,
    parameter bit ODD_DEF = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic             odd_sel,
    input  logic             mode_ld,
    output logic             parity,
    output logic [WIDTH-1:0] out_data,
    output logic             out_par,
    output logic             out_valid,
    input  logic [WIDTH-1:0] chk_data,
    input  logic             chk_par,
    input  logic             chk_valid,
    output logic             par_err,
    output logic [7:0]       err_cnt
);

    logic             mode_q, mode_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_par_q, out_par_d;
    logic             out_valid_q, out_valid_d;
    logic             par_err_q, par_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             chk_exp;

    // mode_q resets to ODD_DEF asynchronously, so parity already tracks ODD_DEF during reset.
    assign parity  = (^in) ^ mode_q;
    assign chk_exp = (^chk_data) ^ mode_q;

    always_comb begin
        mode_d      = mode_q;
        out_data_d  = out_data_q;
        out_par_d   = out_par_q;
        out_valid_d = 1'b0;
        par_err_d   = 1'b0;
        err_cnt_d   = err_cnt_q;

        if (mode_ld) begin
            mode_d = odd_sel;
        end

        if (in_valid) begin
            out_data_d  = in;
            out_par_d   = parity;
            out_valid_d = 1'b1;
        end

        if (chk_valid && (chk_par != chk_exp)) begin
            par_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= ODD_DEF;
            out_data_q  <= '0;
            out_par_q   <= 1'b0;
            out_valid_q <= 1'b0;
            par_err_q   <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            mode_q      <= mode_d;
            out_data_q  <= out_data_d;
            out_par_q   <= out_par_d;
            out_valid_q <= out_valid_d;
            par_err_q   <= par_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_par   = out_par_q;
    assign out_valid = out_valid_q;
    assign par_err   = par_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_parity_gen.sv
// Bench for parity_gen: directed steps plus random traffic checked against a count-of-ones reference model.
module tb_parity_gen;

    localparam int WIDTH   = 3;
    localparam bit ODD_DEF = 1'b0;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] d_in;
    logic             in_valid;
    logic             odd_sel;
    logic             mode_ld;
    logic             parity;
    logic [WIDTH-1:0] out_data;
    logic             out_par;
    logic             out_valid;
    logic [WIDTH-1:0] chk_data;
    logic             chk_par;
    logic             chk_valid;
    logic             par_err;
    logic [7:0]       err_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit             m_mode;
    bit [WIDTH-1:0] m_out_data;
    bit             m_out_par;
    bit             m_out_valid;
    bit             m_par_err;
    int             m_err_cnt;

    parity_gen #(.WIDTH(WIDTH), .ODD_DEF(ODD_DEF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (d_in),
        .in_valid (in_valid),
        .odd_sel  (odd_sel),
        .mode_ld  (mode_ld),
        .parity   (parity),
        .out_data (out_data),
        .out_par  (out_par),
        .out_valid(out_valid),
        .chk_data (chk_data),
        .chk_par  (chk_par),
        .chk_valid(chk_valid),
        .par_err  (par_err),
        .err_cnt  (err_cnt)
    );

    always #10 clk = ~clk;

    function automatic bit ref_par(input bit [WIDTH-1:0] data, input bit odd);
        // A parity bit that makes the total number of ones even (or odd).
        return bit'(($countones(data) % 2) != 0) ^ odd;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".parity"},    32'(parity),    32'(ref_par(d_in, m_mode)));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_out_valid));
        check({tag, ".out_data"},  32'(out_data),  32'(m_out_data));
        check({tag, ".out_par"},   32'(out_par),   32'(m_out_par));
        check({tag, ".par_err"},   32'(par_err),   32'(m_par_err));
        check({tag, ".err_cnt"},   32'(err_cnt),   32'(m_err_cnt));
    endtask

    task automatic drive(input logic [WIDTH-1:0] i, input logic iv, input logic os, input logic ml,
                         input logic [WIDTH-1:0] cd, input logic cp, input logic cv);
        d_in = i; in_valid = iv; odd_sel = os; mode_ld = ml;
        chk_data = cd; chk_par = cp; chk_valid = cv;
    endtask

    // Advance one clock edge; model computes next state from pre-edge values, then all outputs are compared.
    task automatic cycle(input string tag);
        bit err;
        if (in_valid) begin
            m_out_data  = d_in;
            m_out_par   = ref_par(d_in, m_mode);
            m_out_valid = 1'b1;
        end else begin
            m_out_valid = 1'b0;
        end
        err = chk_valid && (chk_par != ref_par(chk_data, m_mode));
        m_par_err = err;
        if (err && m_err_cnt < 255) m_err_cnt++;
        if (mode_ld) m_mode = odd_sel;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        m_mode = ODD_DEF; m_out_data = '0; m_out_par = 0; m_out_valid = 0;
        m_par_err = 0; m_err_cnt = 0;
    endtask

    initial begin
        bit [7:0] sweep_exp;
        sweep_exp = 8'b1001_0110;   // bit k = even parity of k

        // Reset state, including combinational parity during reset
        rst_n = 1'b0;
        drive(3'b000, 0, 0, 0, 3'b000, 0, 0);
        model_reset();
        #5;
        check_all("reset");
        d_in = 3'b001;
        #1;
        check("reset_parity_odd_count", 32'(parity), 32'(ODD_DEF ? 1'b0 : 1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Combinational sweep, even mode
        for (int k = 0; k < 8; k++) begin
            d_in = k[WIDTH-1:0];
            #100;
            check($sformatf("sweep_%0d", k), 32'(parity), 32'(sweep_exp[k]));
        end

        // Switch to odd mode
        drive(3'b000, 0, 1, 1, 3'b000, 0, 0);
        cycle("mode_odd_ld");
        drive(3'b101, 0, 0, 0, 3'b000, 0, 0);
        #1;
        check("odd_101", 32'(parity), 32'd1);
        d_in = 3'b111;
        #1;
        check("odd_111", 32'(parity), 32'd0);

        // Capture uses the old (odd) mode while loading even
        drive(3'b110, 1, 0, 1, 3'b000, 0, 0);
        cycle("capture_old_mode");
        check("capture_old_mode_par", 32'(out_par), 32'd1);

        // Registered path in even mode
        drive(3'b110, 1, 0, 0, 3'b000, 0, 0);
        cycle("reg_110");
        check("reg_110_data", 32'(out_data), 32'(3'b110));
        check("reg_110_par", 32'(out_par), 32'd0);
        check("reg_110_vld", 32'(out_valid), 32'd1);
        drive(3'b011, 0, 0, 0, 3'b000, 0, 0);
        cycle("reg_hold");
        check("reg_hold_vld", 32'(out_valid), 32'd0);
        check("reg_hold_data", 32'(out_data), 32'(3'b110));

        // Checker, even mode
        drive(3'b000, 0, 0, 0, 3'b011, 1, 1);
        cycle("chk_bad");
        check("chk_bad_err", 32'(par_err), 32'd1);
        check("chk_bad_cnt", 32'(err_cnt), 32'd1);
        drive(3'b000, 0, 0, 0, 3'b011, 0, 1);
        cycle("chk_good");
        check("chk_good_err", 32'(par_err), 32'd0);
        check("chk_good_cnt", 32'(err_cnt), 32'd1);

        // Random traffic against the model
        for (int n = 0; n < 200; n++) begin
            drive(WIDTH'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                  WIDTH'($urandom), 1'($urandom), 1'($urandom));
            cycle($sformatf("rand_%0d", n));
        end

        // Saturation: 300 consecutive errors
        for (int n = 0; n < 300; n++) begin
            drive(3'b000, 0, 0, 0, WIDTH'($urandom), 1'b0, 1'b1);
            chk_par = ~ref_par(chk_data, m_mode);
            @(negedge clk);
            m_par_err = 1'b1;
            if (m_err_cnt < 255) m_err_cnt++;
            if (n == 299) begin
                check_all("sat");
            end
            @(posedge clk);
        end
        #1;
        check("sat_cnt", 32'(err_cnt), 32'd255);

        // Mid-stream asynchronous reset with odd mode loaded beforehand
        drive(3'b000, 0, 1, 1, 3'b000, 0, 0);
        cycle("pre_rst_mode");
        drive(3'b101, 1, 0, 0, 3'b001, 0, 1);
        cycle("pre_rst_traffic");
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("mid_rst");
        check("mid_rst_parity", 32'(parity), 32'(ODD_DEF ? 1'b1 : 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'b010, 1, 0, 0, 3'b000, 0, 0);
        cycle("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
